ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_pc.sv | 24 ++
 rtl/ctrl_sequencer.sv | 141 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the control sequencer.
// The step-wait state is only reachable when SEQ_SINGLE_STEP_EN is defined.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXEC      = 3'd2,
        S_HALTED    = 3'd3,
        S_STEP_WAIT = 3'd4
    } state_t;

    localparam int IR_W     = 9;
    localparam int IR_CLASS = 8;   // 0 = ALU op, 1 = control op
    localparam int IR_OP_HI = 7;
    localparam int IR_OP_LO = 5;
    localparam int IR_TG_HI = 4;   // jump target field
    localparam int IR_TG_LO = 0;
    localparam int IR_RA_HI = 3;   // register select field
    localparam int IR_RA_LO = 0;

    localparam logic [2:0] OP_ST   = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JC   = 3'b010;
    localparam logic [2:0] OP_JNC  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;

endpackage

// File: rtl/seq_pc.sv
// Program counter: load has priority over increment; increment wraps at 2^PC_W.
module seq_pc #(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    // PC register with load/increment
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Two-cycle fetch/execute sequencer for a small accumulator datapath.
// Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | after reset, waiting for start
// S_FETCH     | IR captured from instr at the end of this cycle
// S_EXEC      | IR decoded, enables driven for this one cycle, PC updated
// S_HALTED    | HALT executed, PC held, waiting for start to resume
// S_STEP_WAIT | single-step only: instruction done, waiting for step_req
module ctrl_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 5,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic            cy,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step_mode,
    input  logic            step_req,
    output logic            step_ack,
`endif
    output logic [PC_W-1:0] pc_addr,
    output logic [RA_W-1:0] reg_addr,
    output logic [2:0]      alu_code,
    output logic            reg_ce,
    output logic            cy_ce,
    output logic            a_ce,
    output logic            busy,
    output logic            halted
);

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q;
    logic            pc_inc, pc_load;
    logic [2:0]      op;
    logic [PC_W-1:0] target;
    state_t          exec_next;

    assign op     = ir_q[IR_OP_HI:IR_OP_LO];
    assign target = PC_W'(ir_q[IR_TG_HI:IR_TG_LO]);

    seq_pc #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .nReset   (nReset),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (target),
        .pc       (pc_addr)
    );

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register, loaded only in FETCH
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ir_q <= '0;
        end else if (state_q == S_FETCH) begin
            ir_q <= instr;
        end
    end

`ifdef SEQ_SINGLE_STEP_EN
    assign exec_next = step_mode ? S_STEP_WAIT : S_FETCH;
    assign step_ack  = (state_q == S_EXEC) && step_mode;
`else
    assign exec_next = S_FETCH;
`endif

    // Next-state and decode; enables are only ever asserted in EXEC
    always_comb begin
        state_d  = state_q;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        reg_ce   = 1'b0;
        cy_ce    = 1'b0;
        a_ce     = 1'b0;
        alu_code = '0;
        reg_addr = '0;
        busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
        halted   = (state_q == S_HALTED);
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = exec_next;
                if (!ir_q[IR_CLASS]) begin
                    alu_code = op;
                    reg_addr = RA_W'(ir_q[IR_RA_HI:IR_RA_LO]);
                    a_ce     = 1'b1;
                    cy_ce    = 1'b1;
                    pc_inc   = 1'b1;
                end else begin
                    case (op)
                        OP_ST: begin
                            reg_addr = RA_W'(ir_q[IR_RA_HI:IR_RA_LO]);
                            reg_ce   = 1'b1;
                            pc_inc   = 1'b1;
                        end
                        OP_JMP:  pc_load = 1'b1;
                        OP_JC: begin
                            pc_load = cy;
                            pc_inc  = !cy;
                        end
                        OP_JNC: begin
                            pc_load = !cy;
                            pc_inc  = cy;
                        end
                        OP_HALT: begin
                            pc_inc  = 1'b1;
                            state_d = S_HALTED;
                        end
                        default: pc_inc = 1'b1;
                    endcase
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (!step_mode || step_req) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a small program in a bench-side memory
// exercises ALU, ST, JMP, JC/JNC, wrap, HALT/resume and reset during EXEC.
module tb_ctrl_sequencer;

    logic       clk;
    logic       nReset;
    logic       start;
    logic       cy;
    logic [8:0] instr;
    logic [4:0] pc_addr;
    logic [3:0] reg_addr;
    logic [2:0] alu_code;
    logic       reg_ce, cy_ce, a_ce, busy, halted;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_mode, step_req, step_ack;
`endif

    logic [8:0] mem [32];
    int         passed;
    int         total;

    assign instr = mem[pc_addr];

    ctrl_sequencer dut (
        .clk      (clk),
        .nReset   (nReset),
        .start    (start),
        .instr    (instr),
        .cy       (cy),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode(step_mode),
        .step_req (step_req),
        .step_ack (step_ack),
`endif
        .pc_addr  (pc_addr),
        .reg_addr (reg_addr),
        .alu_code (alu_code),
        .reg_ce   (reg_ce),
        .cy_ce    (cy_ce),
        .a_ce     (a_ce),
        .busy     (busy),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in FETCH; leaves the bench at the negedge after EXEC.
    task automatic run_instr(input int cyv, input int pc, input int a, input int rce,
                             input int alu, input int ra);
        cy = cyv[0];
        chk($sformatf("fetch@%0d busy", pc), int'(busy), 1);
        chk($sformatf("fetch@%0d pc", pc), int'(pc_addr), pc);
        chk($sformatf("fetch@%0d enables", pc), int'({reg_ce, cy_ce, a_ce}), 0);
        step();
        chk($sformatf("exec@%0d a_ce", pc), int'(a_ce), a);
        chk($sformatf("exec@%0d cy_ce", pc), int'(cy_ce), a);
        chk($sformatf("exec@%0d reg_ce", pc), int'(reg_ce), rce);
        chk($sformatf("exec@%0d alu_code", pc), int'(alu_code), alu);
        chk($sformatf("exec@%0d reg_addr", pc), int'(reg_addr), ra);
        chk($sformatf("exec@%0d pc", pc), int'(pc_addr), pc);
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        nReset = 1'b0;
        start  = 1'b0;
        cy     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 1'b0;
        step_req  = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 9'h1A0;   // NOP
        mem[0]  = 9'h021;   // ALU code 1, R1
        mem[1]  = 9'h042;   // ALU code 2, R2
        mem[2]  = 9'h150;   // JC 16
        mem[16] = 9'h123;   // JMP 3
        mem[3]  = 9'h105;   // ST R5
        mem[4]  = 9'h150;   // JC 16
        mem[5]  = 9'h16C;   // JNC 12
        mem[12] = 9'h170;   // JNC 16
        mem[13] = 9'h13F;   // JMP 31
        mem[31] = 9'h1A0;   // NOP
        mem[6]  = 9'h1A0;   // NOP
        mem[7]  = 9'h180;   // HALT
        mem[8]  = 9'h0E3;   // ALU code 7, R3

        repeat (2) @(negedge clk);
        chk("reset pc", int'(pc_addr), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset halted", int'(halted), 0);
        chk("reset enables", int'({reg_ce, cy_ce, a_ce}), 0);
        nReset = 1'b1;
        step();
        chk("idle busy", int'(busy), 0);
        chk("idle pc", int'(pc_addr), 0);

        start = 1'b1;                       // held high while busy: must be ignored
        step();
        run_instr(0, 0, 1, 0, 1, 1);
        start = 1'b0;
        run_instr(0, 1, 1, 0, 2, 2);
        run_instr(1, 2, 0, 0, 0, 0);        // JC taken -> 16
        run_instr(0, 16, 0, 0, 0, 0);       // JMP 3
        run_instr(0, 3, 0, 1, 0, 5);        // ST R5
        run_instr(0, 4, 0, 0, 0, 0);        // JC not taken -> 5
        run_instr(0, 5, 0, 0, 0, 0);        // JNC taken -> 12
        run_instr(1, 12, 0, 0, 0, 0);       // JNC not taken -> 13
        run_instr(0, 13, 0, 0, 0, 0);       // JMP 31
        run_instr(0, 31, 0, 0, 0, 0);       // NOP wraps to 0
        run_instr(0, 0, 1, 0, 1, 1);
        run_instr(0, 1, 1, 0, 2, 2);
        run_instr(0, 2, 0, 0, 0, 0);        // JC not taken -> 3
        run_instr(0, 3, 0, 1, 0, 5);
        run_instr(0, 4, 0, 0, 0, 0);
        run_instr(1, 5, 0, 0, 0, 0);        // JNC not taken -> 6
        run_instr(0, 6, 0, 0, 0, 0);
        run_instr(0, 7, 0, 0, 0, 0);        // HALT

        chk("halt halted", int'(halted), 1);
        chk("halt busy", int'(busy), 0);
        chk("halt pc", int'(pc_addr), 8);
        step();
        chk("halt hold", int'(halted), 1);
        chk("halt hold pc", int'(pc_addr), 8);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume halted", int'(halted), 0);
        chk("resume fetch pc", int'(pc_addr), 8);
        step();
        chk("exec@8 a_ce", int'(a_ce), 1);
        chk("exec@8 alu_code", int'(alu_code), 7);
        chk("exec@8 reg_addr", int'(reg_addr), 3);

        #1 nReset = 1'b0;
        #1;
        chk("mid-exec reset enables", int'({reg_ce, cy_ce, a_ce}), 0);
        chk("mid-exec reset alu_code", int'(alu_code), 0);
        chk("mid-exec reset pc", int'(pc_addr), 0);
        chk("mid-exec reset busy", int'(busy), 0);
        @(negedge clk);
        nReset = 1'b1;
        step();
        step();
        chk("post-reset idle busy", int'(busy), 0);
        chk("post-reset idle pc", int'(pc_addr), 0);

        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 0, 1, 0, 1, 1);
        chk("restart pc", int'(pc_addr), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
